// File: rtl/store_pkg.sv
// Shared definitions for the store alignment path: size encodings,
// the store FSM state type and the memory lane count.
package store_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    ERR   = 2'b11
  } state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement for a store: narrows the register value to
// the access size and shifts data and byte enables onto the memory lanes.
// The result spans two words so a store crossing a word boundary can be
// split; the upper half being non-zero marks the store as misaligned.
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]           off,
  input  logic [8*LANES-1:0]   data,
  input  logic [1:0]           size,
  output logic [2*LANES-1:0]   be8,
  output logic [16*LANES-1:0]  data64,
  output logic                 misaligned
);

  logic [LANES-1:0]   mask;
  logic [8*LANES-1:0] data_n;

  // Pick the size mask, zero the unused upper bytes, then shift both by the offset
  always_comb begin
    mask   = '0;
    data_n = '0;
    case (size)
      SZ_BYTE: begin
        mask   = 4'b0001;
        data_n = {24'b0, data[7:0]};
      end
      SZ_HALF: begin
        mask   = 4'b0011;
        data_n = {16'b0, data[15:0]};
      end
      SZ_WORD: begin
        mask   = 4'b1111;
        data_n = data;
      end
      default: begin
        mask   = 4'b0000;
        data_n = '0;
      end
    endcase
    be8        = {{LANES{1'b0}}, mask} << off;
    data64     = {{(8*LANES){1'b0}}, data_n} << {off, 3'b000};
    misaligned = |be8[2*LANES-1:LANES];
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts one store from the pipeline, drives the
// lane-aligned write beat(s) to data memory with a req/gnt handshake and
// pulses st_done on completion or st_err on rejection.
// Optional feature macro STORE_SPLIT_EN: when defined, stores crossing a
// word boundary are written as two beats; otherwise they are rejected.
module store_align_unit
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_done,
  output logic        st_err
);

  state_t      state;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;
  logic [1:0]  hold_size;

  logic [1:0]  lane_off;
  logic [31:0] lane_data;
  logic [1:0]  lane_size;
  logic [7:0]  be8;
  logic [63:0] data64;
  logic        misaligned;
  logic        reject;

  // While idle the aligner looks at the incoming store so the first beat can
  // be registered on the accept edge; afterwards it sees the held copy,
  // which supplies the second beat's lanes.
  always_comb begin
    lane_off  = hold_addr[1:0];
    lane_data = hold_data;
    lane_size = hold_size;
    if (state == IDLE) begin
      lane_off  = st_addr[1:0];
      lane_data = st_data;
      lane_size = st_size;
    end
  end

  store_lane_align u_lane_align (
    .off        (lane_off),
    .data       (lane_data),
    .size       (lane_size),
    .be8        (be8),
    .data64     (data64),
    .misaligned (misaligned)
  );

  // Decide whether an incoming store must take the error path
  always_comb begin
`ifdef STORE_SPLIT_EN
    reject = (st_size == SZ_RSVD);
`else
    reject = (st_size == SZ_RSVD) || misaligned;
`endif
  end

  assign st_ready = (state == IDLE);

  // Store FSM with registered memory-side outputs and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      hold_size <= SZ_BYTE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            hold_addr <= st_addr;
            hold_data <= st_data;
            hold_size <= st_size;
            if (reject) begin
              state  <= ERR;
              st_err <= 1'b1;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_be    <= be8[3:0];
              mem_wdata <= data64[31:0];
            end
          end
        end
        BEAT0: begin
          if (mem_gnt) begin
`ifdef STORE_SPLIT_EN
            if (misaligned) begin
              state     <= BEAT1;
              mem_addr  <= {hold_addr[31:2], 2'b00} + 32'd4;
              mem_be    <= be8[7:4];
              mem_wdata <= data64[63:32];
            end else begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
              st_done   <= 1'b1;
            end
`else
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            st_done   <= 1'b1;
`endif
          end
        end
`ifdef STORE_SPLIT_EN
        BEAT1: begin
          if (mem_gnt) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            st_done   <= 1'b1;
          end
        end
`endif
        ERR: begin
          state  <= IDLE;
          st_err <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          st_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
